// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK flip-flops with parallel load, per-bit change flags
// and a saturating count of edges at which the register contents changed.
module jk_reg_bank #(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] toggled,
  output logic             any_change,
  output logic [CNT_W-1:0] chg_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] toggled_reg;
  logic             any_change_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // JK truth table: 00 hold, 10 set, 01 clear, 11 invert
      assign jk_next[gi] = j[gi] ? (k[gi] ? ~q_reg[gi] : 1'b1)
                                 : (k[gi] ? 1'b0       : q_reg[gi]);
      assign q_next[gi]  = load ? d[gi] : (en ? jk_next[gi] : q_reg[gi]);
    end
  endgenerate

  assign diff = q_next ^ q_reg;

  always_comb begin
    count_next = count_reg;
    if (clr_count) begin
      count_next = '0;
    end else if ((|diff) && (count_reg != CNT_MAX)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg          <= INIT;
      toggled_reg    <= '0;
      any_change_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      q_reg          <= q_next;
      toggled_reg    <= diff;
      any_change_reg <= |diff;
      count_reg      <= count_next;
    end
  end

  assign q          = q_reg;
  assign qn         = ~q_reg;
  assign toggled    = toggled_reg;
  assign any_change = any_change_reg;
  assign chg_count  = count_reg;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed plus random bench for jk_reg_bank (WIDTH=4, CNT_W=3): a behavioural
// model pushes expected results to a queue, popped and checked after each edge.
module tb_jk_reg_bank;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             clr_count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] toggled;
  logic             any_change;
  logic [CNT_W-1:0] chg_count;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] tog;
    logic             any;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic [WIDTH-1:0] m_q;
  logic [CNT_W-1:0] m_cnt;
  int vectors  = 0;
  int errors   = 0;
  int step_num = 0;

  jk_reg_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .INIT(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .j(j), .k(k), .load(load), .d(d),
    .clr_count(clr_count), .q(q), .qn(qn), .toggled(toggled),
    .any_change(any_change), .chg_count(chg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("q", {4'b0, q}, {4'b0, e.q});
    chk("qn", {4'b0, qn}, {4'b0, ~e.q});
    chk("toggled", {4'b0, toggled}, {4'b0, e.tog});
    chk("any_change", {7'b0, any_change}, {7'b0, e.any});
    chk("chg_count", {5'b0, chg_count}, {5'b0, e.cnt});
  endtask

  // Drive one cycle of inputs at the falling edge, model it, check after the rise.
  task automatic step(input logic ld, input logic [WIDTH-1:0] dv, input logic e,
                      input logic [WIDTH-1:0] jv, input logic [WIDTH-1:0] kv,
                      input logic clr);
    logic [WIDTH-1:0] nx;
    exp_t e_push;
    exp_t e_pop;
    @(negedge clk);
    load = ld; d = dv; en = e; j = jv; k = kv; clr_count = clr;
    for (int i = 0; i < WIDTH; i++) begin
      if (ld)                      nx[i] = dv[i];
      else if (!e)                 nx[i] = m_q[i];
      else if (jv[i] && kv[i])     nx[i] = ~m_q[i];
      else if (jv[i])              nx[i] = 1'b1;
      else if (kv[i])              nx[i] = 1'b0;
      else                         nx[i] = m_q[i];
    end
    e_push.q   = nx;
    e_push.tog = nx ^ m_q;
    e_push.any = (nx != m_q);
    if (clr)                           m_cnt = '0;
    else if (nx != m_q && m_cnt != 7)  m_cnt = m_cnt + 1'b1;
    e_push.cnt = m_cnt;
    m_q = nx;
    exp_q.push_back(e_push);
    @(posedge clk);
    #1;
    e_pop = exp_q.pop_front();
    step_num++;
    $display("step %0d: load=%b d=%b en=%b j=%b k=%b clr=%b -> q=%b tog=%b any=%b cnt=%0d",
             step_num, ld, dv, e, jv, kv, clr, q, toggled, any_change, chg_count);
    check_all(e_pop);
  endtask

  task automatic check_reset(input string what);
    exp_t e;
    e.q = 4'b0000; e.tog = '0; e.any = 1'b0; e.cnt = '0;
    $display("%s: q=%b qn=%b tog=%b any=%b cnt=%0d", what, q, qn, toggled, any_change, chg_count);
    check_all(e);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; j = '0; k = '0; load = 1'b0; d = '0; clr_count = 1'b0;
    m_q = '0; m_cnt = '0;
    #12;
    check_reset("reset at start");
    @(negedge clk);
    reset = 1'b1;

    step(1'b1, 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0);
    // Asynchronous reset between edges while loading and counting is requested
    load = 1'b1; d = 4'b1111; en = 1'b1; clr_count = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check_reset("mid-cycle reset");
    m_q = '0; m_cnt = '0;
    @(negedge clk);
    reset = 1'b1;
    load = 1'b0; en = 1'b0; clr_count = 1'b0;

    step(1'b0, 4'b0000, 1'b1, 4'b1100, 4'b0110, 1'b0);
    repeat (3) step(1'b0, 4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0);
    step(1'b1, 4'b0101, 1'b1, 4'b1111, 4'b1111, 1'b0);
    step(1'b1, 4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0);
    repeat (9) step(1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);

    repeat (30) begin
      step(($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
